usb_fs_in_arb: RTL and testbench

- Per-packet round-robin arbiter that shares one IN endpoint producer interface (free/put/data/done/acked) between NUM_REQ byte-stream requesters.
- Sits between client logic (e.g. CDC data sources, debug channels) and one endpoint slot of the IN protocol engine.
- Segments each requester transfer into packets of at most MAX_PKT bytes.
- Holds the grant until the host has acknowledged the final packet of the transfer.

---
 rtl/usb_fs_in_arb_pkg.sv | 18 +
 rtl/usb_rr_arbiter.sv | 33 +++
 rtl/usb_fs_in_arb.sv | 168 ++++++++++++++++
 tb/tb_usb_fs_in_arb.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_fs_in_arb_pkg.sv
// Shared types for the USB full-speed IN endpoint arbiter: FSM state encoding
// and the width helper for the per-packet byte counter.
package usb_fs_in_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    DONE     = 3'd2,
    WAIT_ACK = 3'd3,
    ZLP      = 3'd4
  } state_t;

  // One extra bit so the counter can hold MAX_PKT itself without wrapping.
  function automatic int cnt_width(input int max_pkt);
    return $clog2(max_pkt) + 1;
  endfunction

endpackage

// File: rtl/usb_rr_arbiter.sv
// Combinational round-robin pick: returns the first set request searching
// cyclically from ptr+1, as a one-hot vector plus its index.
module usb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      gnt_idx,
  output logic               any
);

  int idx;

  // Walk from the farthest offset down so the nearest request wins last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/usb_fs_in_arb.sv
// Per-packet round-robin arbiter sharing one USB IN endpoint between NUM_REQ
// byte-stream requesters. Optional trailing ZLP: define USB_FS_IN_ARB_ZLP_EN.
module usb_fs_in_arb
  import usb_fs_in_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_PKT = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ep_reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     req_acked,
  output logic [NUM_REQ-1:0]     grant,
  input  logic                   in_ep_data_free,
  output logic                   in_ep_data_put,
  output logic [7:0]             in_ep_data,
  output logic                   in_ep_data_done,
  input  logic                   in_ep_acked
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(MAX_PKT);
  localparam logic [CW-1:0] PKT_FULL = CW'(MAX_PKT);

  state_t            state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [PW-1:0]     gidx, gidx_nxt;
  logic [PW-1:0]     rr_ptr, rr_nxt;
  logic [CW-1:0]     byte_cnt, cnt_nxt;
  logic              last_seen, last_nxt;
  logic [NUM_REQ-1:0] pick;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic              fill_ok;
  logic              need_zlp;

  usb_rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (pick),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

`ifdef USB_FS_IN_ARB_ZLP_EN
  logic zlp_pend;

  always_ff @(posedge clk) begin
    if (!reset_n || ep_reset) zlp_pend <= 1'b0;
    else if (state_nxt == ZLP) zlp_pend <= 1'b1;
    else if (state_nxt == IDLE) zlp_pend <= 1'b0;
  end

  // A transfer ending on a full packet needs a ZLP so the host sees its end.
  assign need_zlp = (byte_cnt == PKT_FULL) && !zlp_pend;
`else
  assign need_zlp = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    gidx_nxt        = gidx;
    rr_nxt          = rr_ptr;
    cnt_nxt         = byte_cnt;
    last_nxt        = last_seen;
    req_ready       = '0;
    req_acked       = '0;
    in_ep_data_put  = 1'b0;
    in_ep_data      = 8'h00;
    in_ep_data_done = 1'b0;
    fill_ok         = 1'b0;

    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nxt = pick;
          gidx_nxt  = pick_idx;
          cnt_nxt   = '0;
          last_nxt  = 1'b0;
          state_nxt = FILL;
        end
      end
      FILL: begin
        fill_ok         = in_ep_data_free && (byte_cnt < PKT_FULL);
        req_ready[gidx] = fill_ok;
        in_ep_data_put  = req_valid[gidx] && fill_ok;
        in_ep_data      = req_data[{gidx, 3'b000} +: 8];
        if (in_ep_data_put) begin
          cnt_nxt = byte_cnt + CW'(1);
          // A full packet is closed by the engine, so no done pulse here.
          if (cnt_nxt == PKT_FULL) begin
            state_nxt = WAIT_ACK;
            last_nxt  = req_last[gidx];
          end else if (req_last[gidx]) begin
            state_nxt = DONE;
            last_nxt  = 1'b1;
          end
        end
      end
      DONE: begin
        in_ep_data_done = 1'b1;
        state_nxt       = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (in_ep_acked) begin
          if (!last_seen) begin
            cnt_nxt   = '0;
            state_nxt = FILL;
          end else if (need_zlp) begin
            state_nxt = ZLP;
          end else begin
            req_acked[gidx] = 1'b1;
            rr_nxt          = gidx;
            grant_nxt       = '0;
            cnt_nxt         = '0;
            last_nxt        = 1'b0;
            state_nxt       = IDLE;
          end
        end
      end
      ZLP: begin
        if (in_ep_data_free) begin
          in_ep_data_done = 1'b1;
          last_nxt        = 1'b1;
          state_nxt       = WAIT_ACK;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Endpoint reset aborts silently; the round-robin pointer survives.
    if (ep_reset) begin
      state_nxt       = IDLE;
      grant_nxt       = '0;
      cnt_nxt         = '0;
      last_nxt        = 1'b0;
      req_ready       = '0;
      req_acked       = '0;
      in_ep_data_put  = 1'b0;
      in_ep_data      = 8'h00;
      in_ep_data_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      gidx      <= '0;
      rr_ptr    <= '0;
      byte_cnt  <= '0;
      last_seen <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      gidx      <= gidx_nxt;
      rr_ptr    <= rr_nxt;
      byte_cnt  <= cnt_nxt;
      last_seen <= last_nxt;
    end
  end

endmodule

// File: tb/tb_usb_fs_in_arb.sv
// Directed testbench for usb_fs_in_arb (NUM_REQ=4, MAX_PKT=32); the engine
// side is modelled by acking each packet the cycle after it closes.
module tb_usb_fs_in_arb;

  localparam int NUM_REQ = 4;
  localparam int MAX_PKT = 32;

  logic                 clk;
  logic                 reset_n;
  logic                 ep_reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   req_acked;
  logic [NUM_REQ-1:0]   grant;
  logic                 in_ep_data_free;
  logic                 in_ep_data_put;
  logic [7:0]           in_ep_data;
  logic                 in_ep_data_done;
  logic                 in_ep_acked;

  int total = 0;
  int bad   = 0;

  usb_fs_in_arb #(.NUM_REQ(NUM_REQ), .MAX_PKT(MAX_PKT)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ep_reset        (ep_reset),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .req_acked       (req_acked),
    .grant           (grant),
    .in_ep_data_free (in_ep_data_free),
    .in_ep_data_put  (in_ep_data_put),
    .in_ep_data      (in_ep_data),
    .in_ep_data_done (in_ep_data_done),
    .in_ep_acked     (in_ep_acked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] byte_of(input int r, input int i);
    return 8'((r * 64) + i);
  endfunction

  task automatic set_all_valid();
    req_valid = 4'hF;
    req_last  = 4'hF;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  endtask

  // One requester streams n bytes; bench acks each closed packet next cycle.
  task automatic run_xfer(input int r, input int n, input int exp_acks,
                          input int exp_dones, input bit chk_done_time, input string tag);
    int sent, pk, acks, dones, cyc, last_put_cyc, done_cyc;
    bit ack_now, rel, first;
    sent = 0; pk = 0; acks = 0; dones = 0; cyc = 0;
    last_put_cyc = -1; done_cyc = -1;
    ack_now = 1'b0; rel = 1'b0; first = 1'b1;
    while (!rel && cyc < 1000) begin
      req_valid = '0;
      req_last  = '0;
      if (sent < n) begin
        req_valid[r]          = 1'b1;
        req_data[8*r +: 8]    = byte_of(r, sent);
        req_last[r]           = (sent == n - 1);
      end
      in_ep_acked = ack_now;
      ack_now     = 1'b0;
      #1;
      if (in_ep_data_put) begin
        if (first) begin
          chk({tag, "_grant"}, 32'(grant), 32'(1 << r));
          first = 1'b0;
        end
        chk({tag, "_data"}, 32'(in_ep_data), 32'(byte_of(r, sent)));
        sent++;
        pk++;
        last_put_cyc = cyc;
        if (pk == MAX_PKT) begin
          pk      = 0;
          ack_now = 1'b1;
        end
      end
      if (in_ep_data_done) begin
        dones++;
        done_cyc = cyc;
        ack_now  = 1'b1;
        pk       = 0;
      end
      if (in_ep_acked) acks++;
      if (req_acked != '0) begin
        rel = 1'b1;
        chk({tag, "_acked_vec"}, 32'(req_acked), 32'(1 << r));
        chk({tag, "_acks_at_release"}, acks, exp_acks);
      end
      tick();
      cyc++;
    end
    in_ep_acked = 1'b0;
    req_valid   = '0;
    req_last    = '0;
    chk({tag, "_released"}, 32'(rel), 32'd1);
    chk({tag, "_bytes"}, sent, n);
    chk({tag, "_dones"}, dones, exp_dones);
    if (chk_done_time) chk({tag, "_done_timing"}, done_cyc, last_put_cyc + 1);
    #1;
    chk({tag, "_grant_idle"}, 32'(grant), 32'd0);
  endtask

  initial begin
    int exp_order [5];
    int k, cyc, sent;
    bit ack_now;

    reset_n         = 1'b0;
    ep_reset        = 1'b0;
    req_valid       = '0;
    req_data        = '0;
    req_last        = '0;
    in_ep_data_free = 1'b1;
    in_ep_acked     = 1'b0;

    // Reset: outputs quiet even with every requester valid
    @(negedge clk);
    set_all_valid();
    tick();
    tick();
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_put", 32'(in_ep_data_put), 32'd0);
    chk("rst_done", 32'(in_ep_data_done), 32'd0);
    chk("rst_acked", 32'(req_acked), 32'd0);
    chk("rst_data", 32'(in_ep_data), 32'd0);
    req_valid = '0;
    req_last  = '0;
    reset_n   = 1'b1;
    tick();

    // All requesters valid: grants rotate 1,2,3,0,1 from rr_ptr=0
    exp_order = '{1, 2, 3, 0, 1};
    set_all_valid();
    k = 0; cyc = 0; ack_now = 1'b0;
    while (k < 5 && cyc < 200) begin
      in_ep_acked = ack_now;
      ack_now     = 1'b0;
      #1;
      if (in_ep_data_put) begin
        chk("rr_grant", 32'(grant), 32'(1 << exp_order[k]));
        chk("rr_data", 32'(in_ep_data), 32'(8'hA0 + exp_order[k]));
      end
      if (in_ep_data_done) ack_now = 1'b1;
      if (req_acked != '0) begin
        chk("rr_acked", 32'(req_acked), 32'(1 << exp_order[k]));
        k++;
      end
      tick();
      cyc++;
    end
    in_ep_acked = 1'b0;
    req_valid   = '0;
    req_last    = '0;
    chk("rr_rounds", k, 5);
    tick();

    // Short transfer: 5 bytes, done right after the last byte, single ack
    run_xfer(1, 5, 1, 1, 1'b1, "t5");
    // Three packets 32/32/6, done only on the short one
    run_xfer(0, 70, 3, 1, 1'b1, "t70");
    // Exactly two full packets
`ifdef USB_FS_IN_ARB_ZLP_EN
    run_xfer(2, 64, 3, 1, 1'b0, "t64");
`else
    run_xfer(2, 64, 2, 0, 1'b0, "t64");
`endif

    // ep_reset while waiting for the first packet's ack of a 40-byte transfer
    tick();
    sent = 0; cyc = 0;
    while (sent < MAX_PKT && cyc < 100) begin
      req_valid[3]    = 1'b1;
      req_last[3]     = 1'b0;
      req_data[31:24] = byte_of(3, sent);
      #1;
      if (in_ep_data_put) sent++;
      tick();
      cyc++;
    end
    chk("epr_bytes", sent, MAX_PKT);
    #1;
    chk("epr_ready_wait", 32'(req_ready), 32'd0);
    chk("epr_grant_held", 32'(grant), 32'h8);
    ep_reset    = 1'b1;
    in_ep_acked = 1'b1;
    #1;
    chk("epr_no_acked", 32'(req_acked), 32'd0);
    tick();
    ep_reset    = 1'b0;
    in_ep_acked = 1'b0;
    req_valid   = '0;
    #1;
    chk("epr_grant_clear", 32'(grant), 32'd0);
    chk("epr_put_clear", 32'(in_ep_data_put), 32'd0);

    // Re-arbitration resumes after the last completed owner (req2)
    set_all_valid();
    tick();
    #1;
    chk("epr_rearb_grant", 32'(grant), 32'h8);
    chk("epr_rearb_put", 32'(in_ep_data_put), 32'd1);
    chk("epr_rearb_data", 32'(in_ep_data), 32'hA3);

    // reset_n during FILL, then first grant goes to requester 1
    reset_n = 1'b0;
    tick();
    #1;
    chk("rf_grant", 32'(grant), 32'd0);
    chk("rf_put", 32'(in_ep_data_put), 32'd0);
    chk("rf_ready", 32'(req_ready), 32'd0);
    chk("rf_done", 32'(in_ep_data_done), 32'd0);
    chk("rf_data", 32'(in_ep_data), 32'd0);
    reset_n = 1'b1;
    tick();
    #1;
    chk("rf_first_grant", 32'(grant), 32'h2);
    req_valid = '0;
    req_last  = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
